// File: rtl/xcvr_link_reset_seq.sv
// Transceiver link reset sequencer: independent TX/RX reset FSMs with lock
// qualification, restart handling and RX lock-loss counting.
module xcvr_link_reset_seq #(
  parameter int unsigned T_ANA = 32,
  parameter int unsigned T_LTD = 1024,
  parameter int unsigned T_DIG = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       tx_cal_busy,
  input  logic       rx_cal_busy,
  input  logic       rx_is_lockedtodata,
  input  logic       restart,
  output logic       tx_analogreset,
  output logic       tx_digitalreset,
  output logic       rx_analogreset,
  output logic       rx_digitalreset,
  output logic       tx_ready,
  output logic       rx_ready,
  output logic [7:0] link_lost_cnt
);

  localparam int unsigned T_MAX1 = (T_ANA > T_LTD) ? T_ANA : T_LTD;
  localparam int unsigned T_MAX  = (T_MAX1 > T_DIG) ? T_MAX1 : T_DIG;
  localparam int unsigned TMR_W  = $clog2(T_MAX + 1);

  localparam logic [TMR_W-1:0] ANA_LAST = TMR_W'(T_ANA - 1);
  localparam logic [TMR_W-1:0] LTD_LAST = TMR_W'(T_LTD - 1);
  localparam logic [TMR_W-1:0] DIG_LAST = TMR_W'(T_DIG - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

  typedef enum logic [1:0] {TX_ANA, TX_WAIT, TX_DIG, TX_RDY} tx_state_e;
  typedef enum logic [2:0] {RX_ANA, RX_WAIT_CAL, RX_WAIT_LTD, RX_DIG, RX_RDY} rx_state_e;

  logic [3:0]       r_sync1;
  logic [3:0]       r_sync2;
  logic             w_pll;
  logic             w_tx_cal;
  logic             w_rx_cal;
  logic             w_ltd;

  tx_state_e        r_tx_state;
  tx_state_e        w_tx_state_nxt;
  logic [TMR_W-1:0] r_tx_tmr;
  logic [TMR_W-1:0] w_tx_tmr_nxt;
  rx_state_e        r_rx_state;
  rx_state_e        w_rx_state_nxt;
  logic [TMR_W-1:0] r_rx_tmr;
  logic [TMR_W-1:0] w_rx_tmr_nxt;
  logic             w_lost_inc;

  logic             w_tx_ana_nxt;
  logic             w_tx_dig_nxt;
  logic             w_tx_rdy_nxt;
  logic             w_rx_ana_nxt;
  logic             w_rx_dig_nxt;
  logic             w_rx_rdy_nxt;

  logic             r_tx_ana;
  logic             r_tx_dig;
  logic             r_tx_rdy;
  logic             r_rx_ana;
  logic             r_rx_dig;
  logic             r_rx_rdy;
  logic [7:0]       r_lost_cnt;

  // 2-flop synchronizers for the asynchronous status inputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 4'b0000;
      r_sync2 <= 4'b0000;
    end else begin
      r_sync1 <= {pll_locked, tx_cal_busy, rx_cal_busy, rx_is_lockedtodata};
      r_sync2 <= r_sync1;
    end
  end

  assign w_pll    = r_sync2[3];
  assign w_tx_cal = r_sync2[2];
  assign w_rx_cal = r_sync2[1];
  assign w_ltd    = r_sync2[0];

  // State and timer registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_state <= TX_ANA;
      r_tx_tmr   <= '0;
      r_rx_state <= RX_ANA;
      r_rx_tmr   <= '0;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_tmr   <= w_tx_tmr_nxt;
      r_rx_state <= w_rx_state_nxt;
      r_rx_tmr   <= w_rx_tmr_nxt;
    end
  end

  // TX next state; restart overrides every other event
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_tmr_nxt   = r_tx_tmr;
    if (restart) begin
      w_tx_state_nxt = TX_ANA;
      w_tx_tmr_nxt   = '0;
    end else begin
      case (r_tx_state)
        TX_ANA: begin
          if (r_tx_tmr == ANA_LAST) begin
            w_tx_state_nxt = TX_WAIT;
            w_tx_tmr_nxt   = '0;
          end else begin
            w_tx_tmr_nxt = r_tx_tmr + TMR_ONE;
          end
        end
        TX_WAIT: begin
          if (w_pll && !w_tx_cal) begin
            w_tx_state_nxt = TX_DIG;
            w_tx_tmr_nxt   = '0;
          end
        end
        TX_DIG: begin
          if (!w_pll) begin
            w_tx_state_nxt = TX_WAIT;
            w_tx_tmr_nxt   = '0;
          end else if (r_tx_tmr == DIG_LAST) begin
            w_tx_state_nxt = TX_RDY;
            w_tx_tmr_nxt   = '0;
          end else begin
            w_tx_tmr_nxt = r_tx_tmr + TMR_ONE;
          end
        end
        TX_RDY: begin
          if (!w_pll) begin
            w_tx_state_nxt = TX_WAIT;
            w_tx_tmr_nxt   = '0;
          end
        end
        default: begin
          w_tx_state_nxt = TX_ANA;
          w_tx_tmr_nxt   = '0;
        end
      endcase
    end
  end

  // RX next state; the lock-loss counter only bumps when restart is idle
  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_tmr_nxt   = r_rx_tmr;
    w_lost_inc     = 1'b0;
    if (restart) begin
      w_rx_state_nxt = RX_ANA;
      w_rx_tmr_nxt   = '0;
    end else begin
      case (r_rx_state)
        RX_ANA: begin
          if (r_rx_tmr == ANA_LAST) begin
            w_rx_state_nxt = RX_WAIT_CAL;
            w_rx_tmr_nxt   = '0;
          end else begin
            w_rx_tmr_nxt = r_rx_tmr + TMR_ONE;
          end
        end
        RX_WAIT_CAL: begin
          if (!w_rx_cal) begin
            w_rx_state_nxt = RX_WAIT_LTD;
            w_rx_tmr_nxt   = '0;
          end
        end
        RX_WAIT_LTD: begin
          if (!w_ltd) begin
            w_rx_tmr_nxt = '0;
          end else if (r_rx_tmr == LTD_LAST) begin
            w_rx_state_nxt = RX_DIG;
            w_rx_tmr_nxt   = '0;
          end else begin
            w_rx_tmr_nxt = r_rx_tmr + TMR_ONE;
          end
        end
        RX_DIG: begin
          if (!w_ltd) begin
            w_rx_state_nxt = RX_WAIT_LTD;
            w_rx_tmr_nxt   = '0;
          end else if (r_rx_tmr == DIG_LAST) begin
            w_rx_state_nxt = RX_RDY;
            w_rx_tmr_nxt   = '0;
          end else begin
            w_rx_tmr_nxt = r_rx_tmr + TMR_ONE;
          end
        end
        RX_RDY: begin
          if (!w_ltd) begin
            w_rx_state_nxt = RX_WAIT_LTD;
            w_rx_tmr_nxt   = '0;
            w_lost_inc     = 1'b1;
          end
        end
        default: begin
          w_rx_state_nxt = RX_ANA;
          w_rx_tmr_nxt   = '0;
        end
      endcase
    end
  end

  // Output decode from next state so registered outputs track the state
  always_comb begin
    w_tx_ana_nxt = (w_tx_state_nxt == TX_ANA);
    w_tx_dig_nxt = (w_tx_state_nxt != TX_RDY);
    w_tx_rdy_nxt = (w_tx_state_nxt == TX_RDY);
    w_rx_ana_nxt = (w_rx_state_nxt == RX_ANA);
    w_rx_dig_nxt = (w_rx_state_nxt != RX_RDY);
    w_rx_rdy_nxt = (w_rx_state_nxt == RX_RDY);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_ana   <= 1'b1;
      r_tx_dig   <= 1'b1;
      r_tx_rdy   <= 1'b0;
      r_rx_ana   <= 1'b1;
      r_rx_dig   <= 1'b1;
      r_rx_rdy   <= 1'b0;
      r_lost_cnt <= 8'd0;
    end else begin
      r_tx_ana <= w_tx_ana_nxt;
      r_tx_dig <= w_tx_dig_nxt;
      r_tx_rdy <= w_tx_rdy_nxt;
      r_rx_ana <= w_rx_ana_nxt;
      r_rx_dig <= w_rx_dig_nxt;
      r_rx_rdy <= w_rx_rdy_nxt;
      if (w_lost_inc && (r_lost_cnt != 8'hFF)) begin
        r_lost_cnt <= r_lost_cnt + 8'd1;
      end
    end
  end

  assign tx_analogreset  = r_tx_ana;
  assign tx_digitalreset = r_tx_dig;
  assign rx_analogreset  = r_rx_ana;
  assign rx_digitalreset = r_rx_dig;
  assign tx_ready        = r_tx_rdy;
  assign rx_ready        = r_rx_rdy;
  assign link_lost_cnt   = r_lost_cnt;

endmodule

// File: tb/tb_xcvr_link_reset_seq.sv
// Directed bench for xcvr_link_reset_seq with T_ANA=4, T_LTD=8, T_DIG=4.
// Inputs change 1ns after a rising edge; outputs are sampled at that point too.
module tb_xcvr_link_reset_seq;

  logic       clk;
  logic       reset_n;
  logic       pll_locked;
  logic       tx_cal_busy;
  logic       rx_cal_busy;
  logic       rx_is_lockedtodata;
  logic       restart;
  logic       tx_analogreset;
  logic       tx_digitalreset;
  logic       rx_analogreset;
  logic       rx_digitalreset;
  logic       tx_ready;
  logic       rx_ready;
  logic [7:0] link_lost_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  xcvr_link_reset_seq #(
    .T_ANA(4),
    .T_LTD(8),
    .T_DIG(4)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .pll_locked        (pll_locked),
    .tx_cal_busy       (tx_cal_busy),
    .rx_cal_busy       (rx_cal_busy),
    .rx_is_lockedtodata(rx_is_lockedtodata),
    .restart           (restart),
    .tx_analogreset    (tx_analogreset),
    .tx_digitalreset   (tx_digitalreset),
    .rx_analogreset    (rx_analogreset),
    .rx_digitalreset   (rx_digitalreset),
    .tx_ready          (tx_ready),
    .rx_ready          (rx_ready),
    .link_lost_cnt     (link_lost_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {tx_ana, tx_dig, rx_ana, rx_dig, tx_rdy, rx_rdy, cnt[7:0]}
  function automatic logic [13:0] outs();
    return {tx_analogreset, tx_digitalreset, rx_analogreset, rx_digitalreset,
            tx_ready, rx_ready, link_lost_cnt};
  endfunction

  task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Raise lock-to-data and wait (bounded) for rx_ready
  task automatic qualify(input string name);
    bit ok;
    ok = 1'b0;
    rx_is_lockedtodata = 1'b1;
    for (int i = 0; i < 60; i++) begin
      step(1);
      if (rx_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_ready_timeout"}, 14'(ok), 14'd1);
  endtask

  // Qualify, then drop lock-to-data; loss visible 3 edges later
  task automatic drop(input string name, input int exp_cnt);
    qualify(name);
    rx_is_lockedtodata = 1'b0;
    step(2);
    check({name, "_still_ready"}, 14'(rx_ready), 14'd1);
    step(1);
    check({name, "_lost"}, {4'd0, rx_ready, rx_digitalreset, link_lost_cnt},
          {4'd0, 1'b0, 1'b1, 8'(exp_cnt)});
  endtask

  typedef struct {
    logic        pll;
    logic        txc;
    logic        rxc;
    logic        ltd;
    logic        rst;
    int          n;
    logic [13:0] exp;
  } vec_t;

  vec_t vecs[16];

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3, {6'b111100, 8'd0}};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, {6'b010100, 8'd0}};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4, {6'b010100, 8'd0}};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, {6'b000110, 8'd0}};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4, {6'b000110, 8'd0}};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, {6'b000110, 8'd0}};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 9, {6'b000110, 8'd0}};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1, {6'b000110, 8'd0}};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3, {6'b000110, 8'd0}};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1, {6'b000011, 8'd0}};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2, {6'b000011, 8'd0}};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, {6'b010001, 8'd0}};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6, {6'b010001, 8'd0}};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1, {6'b000011, 8'd0}};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2, {6'b000011, 8'd0}};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, {6'b000110, 8'd1}};

    reset_n            = 1'b0;
    pll_locked         = 1'b1;
    tx_cal_busy        = 1'b0;
    rx_cal_busy        = 1'b0;
    rx_is_lockedtodata = 1'b0;
    restart            = 1'b0;
    step(3);
    check("reset_state", outs(), {6'b111100, 8'd0});

    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      pll_locked         = vecs[i].pll;
      tx_cal_busy        = vecs[i].txc;
      rx_cal_busy        = vecs[i].rxc;
      rx_is_lockedtodata = vecs[i].ltd;
      restart            = vecs[i].rst;
      step(vecs[i].n);
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // Restart coinciding with the synced lock loss in RX_RDY
    qualify("rs");
    rx_is_lockedtodata = 1'b0;
    step(2);
    check("rs_pre_ready", 14'(rx_ready), 14'd1);
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    check("rs_ana_entry", outs(), {6'b111100, 8'd1});
    step(1);
    check("rs_ana_hold", outs(), {6'b111100, 8'd1});
    // Second restart while in ANA restarts the full hold
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    step(3);
    check("rs2_ana_hold", outs(), {6'b111100, 8'd1});
    step(1);
    check("rs2_ana_release", outs(), {6'b010100, 8'd1});

    // Repeated lock losses saturate the counter at 255
    for (int k = 1; k <= 300; k++) begin
      drop($sformatf("drop%0d", k), (k + 1 > 255) ? 255 : k + 1);
    end
    check("sat_cnt", 14'(link_lost_cnt), 14'd255);

    // Async reset mid-operation
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_sat", outs(), {6'b111100, 8'd0});
    step(2);
    reset_n = 1'b1;
    drop("m1", 1);
    drop("m2", 2);
    drop("m3", 3);
    rx_is_lockedtodata = 1'b1;
    step(11);
    check("mid_dig", {4'd0, rx_digitalreset, rx_ready, link_lost_cnt},
          {4'd0, 1'b1, 1'b0, 8'd3});
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_dig", outs(), {6'b111100, 8'd0});
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
